// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, reads the eight 16-bit words of the
// 16-byte block from memory, writes each into the data array, then writes the tag.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] cache_fill_addr,
    output logic [15:0] cache_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] base_reg, base_next;
    logic [3:0]  req_cnt_reg, req_cnt_next;
    logic [3:0]  rsp_cnt_reg, rsp_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            base_reg    <= 16'h0000;
            req_cnt_reg <= 4'd0;
            rsp_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            base_reg    <= base_next;
            req_cnt_reg <= req_cnt_next;
            rsp_cnt_reg <= rsp_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        req_cnt_next     = req_cnt_reg;
        rsp_cnt_next     = rsp_cnt_reg;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_fill_addr  = 16'h0000;
        cache_data       = 16'h0000;

        case (state_reg)
            IDLE: begin
                if (miss_detected) begin
                    state_next   = FILL;
                    base_next    = {miss_address[15:4], 4'h0};
                    req_cnt_next = 4'd0;
                    rsp_cnt_next = 4'd0;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                if (req_cnt_reg < 4'd8) begin
                    mem_read_en    = 1'b1;
                    memory_address = base_reg + {11'd0, req_cnt_reg, 1'b0};
                    req_cnt_next   = req_cnt_reg + 4'd1;
                end
                // Only accept a response when a request is actually outstanding.
                if (memory_data_valid && (rsp_cnt_reg < req_cnt_reg)) begin
                    write_data_array = 1'b1;
                    cache_data       = memory_data;
                    cache_fill_addr  = base_reg + {11'd0, rsp_cnt_reg, 1'b0};
                    rsp_cnt_next     = rsp_cnt_reg + 4'd1;
                    if (rsp_cnt_reg == 4'd7) begin
                        state_next = TAG;
                    end
                end
            end

            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                cache_fill_addr = base_reg;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: in-order memory model with random
// latency/gaps, per-cycle behavioural reference, and directed scenarios.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_fill_addr;
    logic [15:0] cache_data;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .cache_fill_addr  (cache_fill_addr),
        .cache_data       (cache_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // ---------------- memory model: in-order, configurable latency and gaps
    int          lat     = 4;
    int          gap_max = 0;
    int          next_ok = 0;
    logic        inject  = 1'b0;
    int          mq_ready[$];
    logic [15:0] mq_addr[$];

    always @(posedge clk) begin
        #2;
        if (mq_ready.size() > 0 && cyc >= next_ok && cyc >= mq_ready[0]) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(mq_addr[0]);
            void'(mq_ready.pop_front());
            void'(mq_addr.pop_front());
            next_ok = cyc + 1 + int'($urandom_range(gap_max, 0));
        end else if (inject && mq_ready.size() == 0) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
    end

    // ---------------- behavioural reference and per-cycle compare
    logic        m_active = 1'b0;
    logic        m_tag    = 1'b0;
    logic [15:0] m_base   = 16'h0;
    int          m_iss    = 0;
    int          m_wr     = 0;
    int          dw_count = 0;
    int          tag_count = 0;
    logic [15:0] last_wr_addr  = 16'h0;
    logic [15:0] first_wr_addr = 16'h0;
    logic [15:0] last_tag_addr = 16'h0;

    logic        e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_maddr, e_faddr, e_data;

    always @(negedge clk) begin
        e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_tag = 1'b0;
        e_maddr = 16'h0; e_faddr = 16'h0; e_data = 16'h0;
        if (rst_n) begin
            e_busy  = m_active || m_tag;
            e_rd    = m_active && (m_iss < 8);
            e_maddr = e_rd ? m_base + 16'(2 * m_iss) : 16'h0;
            e_wr    = m_active && memory_data_valid && (m_wr < m_iss);
            e_tag   = m_tag;
            e_faddr = e_wr ? m_base + 16'(2 * m_wr) : (e_tag ? m_base : 16'h0);
            e_data  = e_wr ? memory_data : 16'h0;
        end
        chk("busy", fsm_busy, e_busy);
        chk("mem_read_en", mem_read_en, e_rd);
        chk("memory_address", memory_address, e_maddr);
        chk("write_data_array", write_data_array, e_wr);
        chk("write_tag_array", write_tag_array, e_tag);
        chk("cache_fill_addr", cache_fill_addr, e_faddr);
        chk("cache_data", cache_data, e_data);

        if (!rst_n) begin
            m_active = 1'b0; m_tag = 1'b0; m_base = 16'h0; m_iss = 0; m_wr = 0;
        end else begin
            if (mem_read_en) begin
                mq_ready.push_back(cyc + lat);
                mq_addr.push_back(memory_address);
            end
            if (write_data_array) begin
                dw_count++;
                last_wr_addr = cache_fill_addr;
                if (m_wr == 0) first_wr_addr = cache_fill_addr;
            end
            if (write_tag_array) begin
                tag_count++;
                last_tag_addr = cache_fill_addr;
            end
            if (e_rd) m_iss++;
            if (e_wr) begin
                m_wr++;
                if (m_wr == 8) begin
                    m_active = 1'b0;
                    m_tag    = 1'b1;
                end
            end else if (m_tag) begin
                m_tag = 1'b0;
            end else if (!m_active && miss_detected) begin
                m_active = 1'b1;
                m_base   = {miss_address[15:4], 4'h0};
                m_iss    = 0;
                m_wr     = 0;
            end
        end
    end

    // ---------------- helpers
    task automatic chk_outputs_zero(string nm);
        chk({nm, "_busy"}, fsm_busy, 0);
        chk({nm, "_rd"}, mem_read_en, 0);
        chk({nm, "_maddr"}, memory_address, 0);
        chk({nm, "_wr"}, write_data_array, 0);
        chk({nm, "_tag"}, write_tag_array, 0);
        chk({nm, "_faddr"}, cache_fill_addr, 0);
        chk({nm, "_data"}, cache_data, 0);
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        @(negedge clk); #1;
        while (fsm_busy && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (fsm_busy) begin
            n_checks++; n_err++;
            $display("FAIL %s: timeout, busy got 1 expected 0", nm);
        end
    endtask

    task automatic wait_drain(string nm);
        int n = 0;
        while ((mq_ready.size() > 0 || memory_data_valid) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (mq_ready.size() > 0) begin
            n_checks++; n_err++;
            $display("FAIL %s: timeout, %0d responses pending expected 0", nm, mq_ready.size());
        end
    endtask

    task automatic run_fill(logic [15:0] a);
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = a;
        @(posedge clk); #1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        wait_idle("fill_done");
    endtask

    // ---------------- stimulus
    int          d0, t0, n;
    logic [15:0] fa, ex;

    initial begin
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Fixed 4-cycle latency, miss at cycle 0 for address 0x1236
        lat = 4; gap_max = 0;
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        @(negedge clk); #1;
        chk("c0_busy", fsm_busy, 0);
        @(posedge clk); #1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk); #1;
            chk($sformatf("c%0d_busy", k), fsm_busy, (k <= 13) ? 1 : 0);
            chk($sformatf("c%0d_rd", k), mem_read_en, (k <= 8) ? 1 : 0);
            chk($sformatf("c%0d_maddr", k), memory_address,
                (k <= 8) ? 32'(16'h1230 + 16'(2 * (k - 1))) : 0);
            chk($sformatf("c%0d_wr", k), write_data_array, (k >= 5 && k <= 12) ? 1 : 0);
            chk($sformatf("c%0d_tag", k), write_tag_array, (k == 13) ? 1 : 0);
            fa = (k >= 5 && k <= 12) ? 16'h1230 + 16'(2 * (k - 5)) :
                 (k == 13) ? 16'h1230 : 16'h0;
            chk($sformatf("c%0d_faddr", k), cache_fill_addr, fa);
            ex = (k >= 5 && k <= 12) ? mem_word(fa) : 16'h0;
            chk($sformatf("c%0d_data", k), cache_data, ex);
        end
        $display("txn fill 0x1236 fixed latency: dw=%0d tags=%0d", dw_count, tag_count);

        // Top-of-memory block, random gaps: no wrap past 0xFFFE
        lat = 2; gap_max = 3;
        d0 = dw_count; t0 = tag_count;
        run_fill(16'hFFF8);
        chk("top_first_wr", first_wr_addr, 16'hFFF0);
        chk("top_last_wr", last_wr_addr, 16'hFFFE);
        chk("top_tag_addr", last_tag_addr, 16'hFFF0);
        chk("top_dw_count", dw_count - d0, 8);
        chk("top_tag_count", tag_count - t0, 1);
        $display("txn fill 0xFFF8 random gaps: writes=%0d tag=0x%h", dw_count - d0, last_tag_addr);

        // Spurious valid in IDLE, spurious miss during FILL
        d0 = dw_count; t0 = tag_count;
        @(posedge clk); #1; inject = 1'b1;
        repeat (3) @(posedge clk);
        #1; inject = 1'b0;
        @(negedge clk); #1;
        chk("idle_valid_no_write", dw_count - d0, 0);
        chk("idle_valid_busy", fsm_busy, 0);
        lat = 3; gap_max = 2;
        @(posedge clk); #1;
        miss_detected = 1'b1; miss_address = 16'h2345;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            miss_detected = k[0]; miss_address = 16'h9990;
        end
        miss_detected = 1'b0; miss_address = 16'h0;
        wait_idle("spurious_miss");
        chk("spur_tag_addr", last_tag_addr, 16'h2340);
        chk("spur_first_wr", first_wr_addr, 16'h2340);
        chk("spur_dw_count", dw_count - d0, 8);
        chk("spur_tag_count", tag_count - t0, 1);
        $display("txn spurious pulses: writes=%0d tag=0x%h", dw_count - d0, last_tag_addr);

        // Reset after the third data write
        lat = 4; gap_max = 0;
        wait_drain("pre_reset_drain");
        d0 = dw_count; t0 = tag_count;
        @(posedge clk); #1;
        miss_detected = 1'b1; miss_address = 16'h4A1C;
        @(posedge clk); #1;
        miss_detected = 1'b0; miss_address = 16'h0;
        n = 0;
        while (dw_count < d0 + 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (dw_count < d0 + 3) begin
            n_checks++; n_err++;
            $display("FAIL rst_wait: timeout, writes got %0d expected 3", dw_count - d0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midfill_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_drain("residual_drain");
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dw_count", dw_count - d0, 3);
        chk("rst_no_tag", tag_count - t0, 0);
        chk("rst_busy", fsm_busy, 0);
        d0 = dw_count; t0 = tag_count;
        run_fill(16'h7777);
        chk("post_rst_first", first_wr_addr, 16'h7770);
        chk("post_rst_last", last_wr_addr, 16'h777E);
        chk("post_rst_tag", last_tag_addr, 16'h7770);
        chk("post_rst_dw", dw_count - d0, 8);
        $display("txn reset mid-fill then refill: writes=%0d tag=0x%h", dw_count - d0, last_tag_addr);

        // Randomised traffic against the reference
        d0 = dw_count; t0 = tag_count;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (c % 100 == 0) begin
                lat = int'($urandom_range(6, 1));
                gap_max = 3;
            end
            miss_detected = ($urandom % 5) == 0;
            miss_address  = 16'($urandom);
            inject        = ($urandom % 6) == 0;
        end
        miss_detected = 1'b0; inject = 1'b0;
        wait_idle("random_idle");
        wait_drain("random_drain");
        chk("random_write_ratio", dw_count - d0, 8 * (tag_count - t0));
        $display("txn random phase: fills=%0d writes=%0d", tag_count - t0, dw_count - d0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
